// File: rtl/if_ex_pipeline_pkg.sv
// if_ex_pipeline_pkg: shared MIPS encodings, ID/EX register layout and forwarding helper.
package mips_pkg;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_LUI   = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        alu_src;
        logic        reg_dst;
        logic [3:0]  alu_op;
        logic [31:0] imm;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [5:0]  funct;
    } id_ex_t;

    // Select code 11 is unused by the forwarding unit and falls back to the register value.
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_val,
                                            input logic [31:0] wb_val, input logic [31:0] mem_val);
        return sel == FWD_WB ? wb_val : sel == FWD_MEM ? mem_val : reg_val;
    endfunction
endpackage

// File: rtl/if_ex_pipeline_if.sv
// if_ex_pipeline_if: fetch/decode inputs, forwarding inputs and execute-stage outputs.
interface if_ex_pipeline_if;
    logic        hazard, flushId;
    logic [31:0] pcIf, instructionIf, pcId, instructionId;
    logic        memToRegId, regWriteId, memWriteId, memReadId, aluSrcId, regDstId;
    logic [3:0]  aluOpId;
    logic [31:0] immediateExtendedId, dataRsId, dataRtId;
    logic [4:0]  addressRsId, addressRtId, addressRdId;
    logic [5:0]  funcId;
    logic [1:0]  forwardingMux0Ex, forwardingMux1Ex;
    logic [31:0] regWriteDataWb, aluResultMem;
    logic        memToRegExOutput, regWriteExOutput, memWriteExOutput, memReadExOutput;
    logic [31:0] aluResultEx, memWriteDataEx;
    logic [4:0]  regWriteRegisterEx;
    logic        aluResultZeroEx;

    modport master (
        output hazard, flushId, pcIf, instructionIf,
        output memToRegId, regWriteId, memWriteId, memReadId, aluSrcId, regDstId, aluOpId,
        output immediateExtendedId, dataRsId, dataRtId, addressRsId, addressRtId, addressRdId, funcId,
        output forwardingMux0Ex, forwardingMux1Ex, regWriteDataWb, aluResultMem,
        input  pcId, instructionId,
        input  memToRegExOutput, regWriteExOutput, memWriteExOutput, memReadExOutput,
        input  aluResultEx, memWriteDataEx, regWriteRegisterEx, aluResultZeroEx
    );

    modport slave (
        input  hazard, flushId, pcIf, instructionIf,
        input  memToRegId, regWriteId, memWriteId, memReadId, aluSrcId, regDstId, aluOpId,
        input  immediateExtendedId, dataRsId, dataRtId, addressRsId, addressRtId, addressRdId, funcId,
        input  forwardingMux0Ex, forwardingMux1Ex, regWriteDataWb, aluResultMem,
        output pcId, instructionId,
        output memToRegExOutput, regWriteExOutput, memWriteExOutput, memReadExOutput,
        output aluResultEx, memWriteDataEx, regWriteRegisterEx, aluResultZeroEx
    );
endinterface

// File: rtl/if_ex_pipeline_alu.sv
// alu: MIPS execute-stage ALU; aluOp selects a class, R-type decodes funct.
module alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);
    logic [31:0] rtype;
    logic        lt_s, lt_u;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        case (funct)
            FN_ADD:  rtype = a + b;
            FN_SUB:  rtype = a - b;
            FN_AND:  rtype = a & b;
            FN_OR:   rtype = a | b;
            FN_XOR:  rtype = a ^ b;
            FN_NOR:  rtype = ~(a | b);
            FN_SLT:  rtype = {31'b0, lt_s};
            FN_SLTU: rtype = {31'b0, lt_u};
            FN_SLL:  rtype = b << shamt;
            FN_SRL:  rtype = b >> shamt;
            FN_SRA:  rtype = $unsigned($signed(b) >>> shamt);
            default: rtype = '0;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SUB:   result = a - b;
            ALU_RTYPE: result = rtype;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_SLT:   result = {31'b0, lt_s};
            ALU_LUI:   result = {b[15:0], 16'h0};
            ALU_XOR:   result = a ^ b;
            default:   result = a + b;
        endcase
    end

    assign zero = result == '0;
endmodule

// File: rtl/if_ex_pipeline.sv
// if_ex_pipeline: IF/ID and ID/EX pipeline registers plus the combinational execute stage.
module if_ex_pipeline
    import mips_pkg::*;
(
    input logic           clk,
    input logic           reset,
    if_ex_pipeline_if.slave bus
);
    logic [31:0] pc_d, pc_q, instr_d, instr_q;
    id_ex_t      id_ex_d, id_ex_q;
    logic [31:0] op_a, rt_fwd, op_b;

    // Flush outranks stall so a taken branch never keeps a wrong-path instruction.
    always_comb begin
        pc_d    = bus.flushId ? 32'h0 : bus.hazard ? pc_q : bus.pcIf;
        instr_d = bus.flushId ? NOP : bus.hazard ? instr_q : bus.instructionIf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= NOP;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // A stall turns the decoded instruction into a bubble by dropping its side effects.
    always_comb begin
        id_ex_d.mem_to_reg = bus.memToRegId & ~bus.hazard;
        id_ex_d.reg_write  = bus.regWriteId & ~bus.hazard;
        id_ex_d.mem_write  = bus.memWriteId & ~bus.hazard;
        id_ex_d.mem_read   = bus.memReadId & ~bus.hazard;
        id_ex_d.alu_src    = bus.aluSrcId;
        id_ex_d.reg_dst    = bus.regDstId;
        id_ex_d.alu_op     = bus.aluOpId;
        id_ex_d.imm        = bus.immediateExtendedId;
        id_ex_d.rs_data    = bus.dataRsId;
        id_ex_d.rt_data    = bus.dataRtId;
        id_ex_d.rt_addr    = bus.addressRtId;
        id_ex_d.rd_addr    = bus.addressRdId;
        id_ex_d.funct      = bus.funcId;
    end

    always_ff @(posedge clk) begin
        if (reset) id_ex_q <= '0;
        else id_ex_q <= id_ex_d;
    end

    always_comb begin
        op_a   = fwd_mux(bus.forwardingMux0Ex, id_ex_q.rs_data, bus.regWriteDataWb, bus.aluResultMem);
        rt_fwd = fwd_mux(bus.forwardingMux1Ex, id_ex_q.rt_data, bus.regWriteDataWb, bus.aluResultMem);
        op_b   = id_ex_q.alu_src ? id_ex_q.imm : rt_fwd;
    end

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .alu_op (id_ex_q.alu_op),
        .funct  (id_ex_q.funct),
        .shamt  (id_ex_q.imm[10:6]),
        .result (bus.aluResultEx),
        .zero   (bus.aluResultZeroEx)
    );

    assign bus.pcId               = pc_q;
    assign bus.instructionId      = instr_q;
    assign bus.memToRegExOutput   = id_ex_q.mem_to_reg;
    assign bus.regWriteExOutput   = id_ex_q.reg_write;
    assign bus.memWriteExOutput   = id_ex_q.mem_write;
    assign bus.memReadExOutput    = id_ex_q.mem_read;
    assign bus.memWriteDataEx     = rt_fwd;
    assign bus.regWriteRegisterEx = id_ex_q.reg_dst ? id_ex_q.rd_addr : id_ex_q.rt_addr;
endmodule

// File: tb/tb_if_ex_pipeline.sv
// tb_if_ex_pipeline: directed scenarios plus randomized traffic against a behavioural MIPS model.
module tb_if_ex_pipeline;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    if_ex_pipeline_if bus ();

    if_ex_pipeline dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] r,
                                            input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return r;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        int sa, sb;
        sa = a;
        sb = b;
        if (op == 4'd1) return a - b;
        if (op == 4'd3) return a & b;
        if (op == 4'd4) return a | b;
        if (op == 4'd5) return (sa < sb) ? 32'd1 : 32'd0;
        if (op == 4'd6) return b * 32'd65536;
        if (op == 4'd7) return a ^ b;
        if (op == 4'd2) begin
            case (fn)
                6'h20: return a + b;
                6'h22: return a - b;
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2a: return (sa < sb) ? 32'd1 : 32'd0;
                6'h2b: return (a < b) ? 32'd1 : 32'd0;
                6'h00: return b << sh;
                6'h02: return b >> sh;
                6'h03: return sb >>> sh;
                default: return 32'd0;
            endcase
        end
        return a + b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [31:0] imm, input logic src,
                            input logic dst, input logic [4:0] rt_a, input logic [4:0] rd_a);
        bus.aluOpId = op; bus.funcId = fn; bus.dataRsId = rs; bus.dataRtId = rt;
        bus.immediateExtendedId = imm; bus.aluSrcId = src; bus.regDstId = dst;
        bus.addressRtId = rt_a; bus.addressRdId = rd_a; bus.addressRsId = 5'd0;
        bus.memToRegId = 0; bus.regWriteId = 0; bus.memWriteId = 0; bus.memReadId = 0;
        bus.forwardingMux0Ex = 2'b00; bus.forwardingMux1Ex = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1; bus.hazard = 0; bus.flushId = 0;
        bus.pcIf = 32'h1234; bus.instructionIf = 32'hDEAD_BEEF;
        drive_id(4'd2, 6'h20, 32'd5, 32'd7, 32'd9, 1'b0, 1'b1, 5'd3, 5'd8);
        bus.regWriteId = 1; bus.memReadId = 1;
        bus.regWriteDataWb = 32'h55; bus.aluResultMem = 32'h66;
        step(); step();
        checks++; if (bus.pcId !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.pcId); end
        checks++; if (bus.instructionId !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", bus.instructionId); end
        checks++;
        if ({bus.memToRegExOutput, bus.regWriteExOutput, bus.memWriteExOutput, bus.memReadExOutput} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000",
                {bus.memToRegExOutput, bus.regWriteExOutput, bus.memWriteExOutput, bus.memReadExOutput});
        end
        checks++; if (bus.aluResultEx !== 32'h0) begin errors++; $display("FAIL reset_alu got %h want 0", bus.aluResultEx); end
        checks++; if (bus.aluResultZeroEx !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", bus.aluResultZeroEx); end
        checks++; if (bus.regWriteRegisterEx !== 5'd0) begin errors++; $display("FAIL reset_dst got %0d want 0", bus.regWriteRegisterEx); end
        checks++; if (bus.memWriteDataEx !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus.memWriteDataEx); end
        reset = 0;
    endtask

    task automatic test_load();
        bus.pcIf = 32'h4; bus.instructionIf = 32'h012A_4020;
        step();
        checks++; if (bus.pcId !== 32'h4) begin errors++; $display("FAIL load_pc got %h want 4", bus.pcId); end
        checks++; if (bus.instructionId !== 32'h012A_4020) begin errors++; $display("FAIL load_instr got %h want 012a4020", bus.instructionId); end
    endtask

    task automatic test_stall_flush();
        bus.pcIf = 32'h8; bus.instructionIf = 32'hAAAA_5555; bus.regWriteId = 1; bus.hazard = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.pcId !== 32'h4) begin errors++; $display("FAIL stall_pc cycle %0d got %h want 4", i, bus.pcId); end
            checks++; if (bus.instructionId !== 32'h012A_4020) begin errors++; $display("FAIL stall_instr cycle %0d got %h", i, bus.instructionId); end
            checks++; if (bus.regWriteExOutput !== 1'b0) begin errors++; $display("FAIL stall_bubble cycle %0d got %b want 0", i, bus.regWriteExOutput); end
        end
        bus.hazard = 0; bus.flushId = 1;
        step();
        checks++; if (bus.instructionId !== 32'h0) begin errors++; $display("FAIL flush_instr got %h want 0", bus.instructionId); end
        checks++; if (bus.regWriteExOutput !== 1'b1) begin errors++; $display("FAIL flush_idex_load got %b want 1", bus.regWriteExOutput); end
        bus.flushId = 0; bus.pcIf = 32'h20; step();
        bus.hazard = 1; bus.flushId = 1;
        step();
        checks++; if (bus.pcId !== 32'h0) begin errors++; $display("FAIL both_pc got %h want 0", bus.pcId); end
        checks++; if (bus.regWriteExOutput !== 1'b0) begin errors++; $display("FAIL both_bubble got %b want 0", bus.regWriteExOutput); end
        bus.hazard = 0; bus.flushId = 0;
    endtask

    task automatic test_rtype_add();
        drive_id(4'b0010, 6'b100000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd3, 5'd8);
        step();
        checks++; if (bus.aluResultEx !== 32'd12) begin errors++; $display("FAIL radd_result got %0d want 12", bus.aluResultEx); end
        checks++; if (bus.regWriteRegisterEx !== 5'd8) begin errors++; $display("FAIL radd_dst got %0d want 8", bus.regWriteRegisterEx); end
        checks++; if (bus.aluResultZeroEx !== 1'b0) begin errors++; $display("FAIL radd_zero got %b want 0", bus.aluResultZeroEx); end
    endtask

    task automatic test_forwarding();
        drive_id(4'b0010, 6'b100010, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd3, 5'd9);
        step();
        bus.forwardingMux0Ex = 2'b10; bus.aluResultMem = 32'd100;
        bus.forwardingMux1Ex = 2'b01; bus.regWriteDataWb = 32'd3;
        #1;
        checks++; if (bus.aluResultEx !== 32'd97) begin errors++; $display("FAIL fwd_sub got %0d want 97", bus.aluResultEx); end
        checks++; if (bus.memWriteDataEx !== 32'd3) begin errors++; $display("FAIL fwd_wdata got %0d want 3", bus.memWriteDataEx); end
        bus.forwardingMux0Ex = 2'b11; bus.forwardingMux1Ex = 2'b11;
        #1;
        checks++; if (bus.aluResultEx !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fwd_sel11 got %h want ffffffff", bus.aluResultEx); end
    endtask

    task automatic test_store_branch();
        drive_id(4'b0000, 6'h00, 32'h10, 32'hAB, 32'hFFFF_FFFC, 1'b1, 1'b0, 5'd5, 5'd9);
        bus.memWriteId = 1;
        step();
        checks++; if (bus.aluResultEx !== 32'hC) begin errors++; $display("FAIL sw_addr got %h want c", bus.aluResultEx); end
        checks++; if (bus.memWriteDataEx !== 32'hAB) begin errors++; $display("FAIL sw_data got %h want ab", bus.memWriteDataEx); end
        checks++; if (bus.memWriteExOutput !== 1'b1) begin errors++; $display("FAIL sw_ctrl got %b want 1", bus.memWriteExOutput); end
        drive_id(4'b0001, 6'h00, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 5'd5, 5'd9);
        step();
        checks++; if (bus.aluResultZeroEx !== 1'b1) begin errors++; $display("FAIL beq_zero got %b want 1", bus.aluResultZeroEx); end
    endtask

    task automatic test_shift_compare();
        drive_id(4'b0010, 6'b000011, 32'd0, 32'h8000_0000, 32'h0000_0100, 1'b0, 1'b1, 5'd1, 5'd2);
        step();
        checks++; if (bus.aluResultEx !== 32'hF800_0000) begin errors++; $display("FAIL sra got %h want f8000000", bus.aluResultEx); end
        drive_id(4'b0010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd1, 5'd2);
        step();
        checks++; if (bus.aluResultEx !== 32'd1) begin errors++; $display("FAIL slt got %h want 1", bus.aluResultEx); end
        drive_id(4'b0010, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd1, 5'd2);
        step();
        checks++; if (bus.aluResultEx !== 32'd0) begin errors++; $display("FAIL sltu got %h want 0", bus.aluResultEx); end
    endtask

    task automatic test_reset_midstream();
        bus.pcIf = 32'h44; bus.instructionIf = 32'h1111_2222;
        drive_id(4'b0000, 6'h00, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 5'd6, 5'd7);
        bus.regWriteId = 1;
        step();
        reset = 1; bus.hazard = 1; bus.flushId = 1;
        step();
        checks++;
        if ({bus.pcId, bus.instructionId, bus.regWriteExOutput, bus.regWriteRegisterEx, bus.aluResultEx} !== '0) begin
            errors++; $display("FAIL midreset pc %h instr %h rw %b dst %0d alu %h want all 0",
                bus.pcId, bus.instructionId, bus.regWriteExOutput, bus.regWriteRegisterEx, bus.aluResultEx);
        end
        reset = 0; bus.hazard = 0; bus.flushId = 0;
    endtask

    task automatic test_random();
        logic [5:0] fn_tab [12];
        logic [31:0] exp_pc, exp_instr, a, rtf, b, exp_res;
        logic [31:0] rs, rt, imm, wb, mem;
        logic [3:0] op, ctl, exp_ctl;
        logic [5:0] fn;
        logic [1:0] f0, f1;
        logic [4:0] rt_a, rd_a, exp_dst;
        logic src, dst, hz, fl;
        int bad;
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h3f};
        reset = 1; step(); reset = 0;
        exp_pc = 0; exp_instr = 0; bad = 0;
        for (int n = 0; n < 300; n++) begin
            hz = ($urandom_range(0, 3) == 0); fl = ($urandom_range(0, 4) == 0);
            op = 4'($urandom_range(0, 15));
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 11)];
            rs = $urandom; rt = $urandom; imm = $urandom; wb = $urandom; mem = $urandom;
            if ($urandom_range(0, 3) == 0) rt = rs;
            ctl = 4'($urandom); src = 1'($urandom); dst = 1'($urandom);
            rt_a = 5'($urandom); rd_a = 5'($urandom); f0 = 2'($urandom); f1 = 2'($urandom);
            bus.hazard = hz; bus.flushId = fl; bus.pcIf = $urandom; bus.instructionIf = $urandom;
            drive_id(op, fn, rs, rt, imm, src, dst, rt_a, rd_a);
            {bus.memToRegId, bus.regWriteId, bus.memWriteId, bus.memReadId} = ctl;
            bus.forwardingMux0Ex = f0; bus.forwardingMux1Ex = f1;
            bus.regWriteDataWb = wb; bus.aluResultMem = mem;
            if (fl) begin exp_pc = 0; exp_instr = 0; end
            else if (!hz) begin exp_pc = bus.pcIf; exp_instr = bus.instructionIf; end
            step();
            a = fwd_ref(f0, rs, wb, mem); rtf = fwd_ref(f1, rt, wb, mem); b = src ? imm : rtf;
            exp_res = alu_ref(op, fn, a, b, imm[10:6]);
            exp_ctl = hz ? 4'b0 : ctl;
            exp_dst = dst ? rd_a : rt_a;
            checks++;
            if ({bus.pcId, bus.instructionId} !== {exp_pc, exp_instr}) begin
                errors++;
                if (bad++ < 5) $display("FAIL rand_ifid iter %0d got %h/%h want %h/%h", n, bus.pcId, bus.instructionId, exp_pc, exp_instr);
            end
            checks++;
            if ({bus.aluResultEx, bus.aluResultZeroEx, bus.memWriteDataEx, bus.regWriteRegisterEx,
                 bus.memToRegExOutput, bus.regWriteExOutput, bus.memWriteExOutput, bus.memReadExOutput}
                !== {exp_res, exp_res == 0, rtf, exp_dst, exp_ctl}) begin
                errors++;
                if (bad++ < 5) $display("FAIL rand_ex iter %0d op %h fn %h got res %h z %b wd %h dst %0d ctl %b want res %h wd %h dst %0d ctl %b",
                    n, op, fn, bus.aluResultEx, bus.aluResultZeroEx, bus.memWriteDataEx, bus.regWriteRegisterEx,
                    {bus.memToRegExOutput, bus.regWriteExOutput, bus.memWriteExOutput, bus.memReadExOutput},
                    exp_res, rtf, exp_dst, exp_ctl);
            end
        end
        bus.hazard = 0; bus.flushId = 0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall_flush();
        test_rtype_add();
        test_forwarding();
        test_store_branch();
        test_shift_compare();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
